// File: rtl/step_ctrl_pkg.sv
// Shared constants for the run/halt/single-step controller.
// Latency: none (package only).
// Backpressure: none (package only).
package step_ctrl_pkg;

    // FSM encoding; 2'd3 is unused and recovers to HALT
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HALT = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    // Board build: 20 ms debounce and a 1 Hz advance tick at 50 MHz
    localparam int unsigned BOARD_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned BOARD_TICK_DIV        = 50000000;
    localparam int unsigned DEFAULT_CNT_W         = 32;

    // Simulation scale, short enough to walk through by hand
    localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;
    localparam int unsigned SIM_TICK_DIV        = 3;

    // Bits needed to hold values 0..max_val, never less than one bit
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : step_ctrl_pkg

// File: rtl/step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce filter, press pulse.
// Latency: raw level first sampled at edge N gives press high in cycle N+2+DEBOUNCE_CYCLES.
// Backpressure: none; press is a one-cycle pulse and is lost if the consumer ignores it.
module btn_debounce
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    // The counter only has to hold 0..DEBOUNCE_CYCLES-1: the cycle that
    // would take it to DEBOUNCE_CYCLES accepts the level and clears it.
    localparam int unsigned      DW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]    DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          stable_dly_q;
    logic          press_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    // Debounce filter: count consecutive disagreeing cycles; any agreeing
    // cycle (a bounce back) restarts the count from zero.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == DB_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    // Synchronizer, filter state and registered rising-edge detect of the
    // stable level; releases never produce a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= stable_q & ~stable_dly_q;
            cnt_q        <= cnt_d;
        end
    end

    assign press = press_q;

endmodule : btn_debounce

// File: rtl/step_ctrl.sv
// Run/halt/single-step controller producing the pipeline advance enable cpu_en.
// Latency: RUN issues cpu_en every TICK_DIV cycles; a press acts one cycle after its debounced pulse.
// Backpressure: none; presses arriving while in STEP are dropped, the pipeline cannot stall this block.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
    parameter int unsigned TICK_DIV        = BOARD_TICK_DIV,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_pause,
    input  logic             btn_step,
    output logic             cpu_en,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
);

    localparam int unsigned   TW        = cnt_width(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic             pause_press;
    logic             step_press;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [TW-1:0]    tick_q;
    logic [TW-1:0]    tick_d;
    logic             cpu_en_q;
    logic             cpu_en_d;
    logic             halted_q;
    logic             halted_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_pause_db (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_pause),
        .press   (pause_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_step),
        .press   (step_press)
    );

    // Next-state logic. cpu_en_d is decided together with the next state
    // so the registered enable lines up with the state it belongs to: a
    // pause press in RUN kills a coinciding tick, and entering STEP
    // raises cpu_en in the same cycle STEP becomes visible.
    always_comb begin
        state_d  = state_q;
        tick_d   = '0;
        cpu_en_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (pause_press) begin
                    state_d = ST_HALT;
                end else if (tick_q == TICK_LAST) begin
                    cpu_en_d = 1'b1;
                    tick_d   = '0;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            ST_HALT: begin
                // Pause has priority; a simultaneous step press is dropped.
                // The tick counter is held at zero so RUN restarts a full
                // TICK_DIV period before its first enable.
                if (pause_press) begin
                    state_d = ST_RUN;
                end else if (step_press) begin
                    state_d  = ST_STEP;
                    cpu_en_d = 1'b1;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        halted_d = (state_d != ST_RUN);
        count_d  = count_q + CNT_W'(cpu_en_d);
    end

    // State, tick counter and registered outputs; step_count wraps freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            tick_q   <= '0;
            cpu_en_q <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            cpu_en_q <= cpu_en_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign halted     = halted_q;
    assign step_count = count_q;

endmodule : step_ctrl

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl at simulation scale (debounce 4, tick 3, 8-bit count).
// Latency: checks are taken 1 time unit after each rising clk edge.
// Backpressure: none.
module tb_step_ctrl;
    import step_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic       btn_pause;
    logic       btn_step;
    logic       cpu_en;
    logic       halted;
    logic [7:0] step_count;

    int vectors;
    int miscompares;
    int cyc;

    step_ctrl #(
        .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES),
        .TICK_DIV        (SIM_TICK_DIV),
        .CNT_W           (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_pause  (btn_pause),
        .btn_step   (btn_step),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .step_count (step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle; cyc numbers the edge just taken.
    task automatic adv();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_out(input logic exp_en, input logic exp_halted);
        chk("cpu_en", {31'd0, cpu_en}, {31'd0, exp_en});
        chk("halted", {31'd0, halted}, {31'd0, exp_halted});
    endtask

    initial begin
        logic [6:0] bounce;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        reset       = 1'b1;
        btn_pause   = 1'b0;
        btn_step    = 1'b0;
        bounce      = 7'b0111011;   // applied LSB first: 1,1,0,1,1,1,0

        // Reset state
        adv();
        chk_out(1'b0, 1'b0);
        chk("rst_count", {24'd0, step_count}, 32'd0);
        adv();
        chk_out(1'b0, 1'b0);
        chk("rst_count", {24'd0, step_count}, 32'd0);
        cyc   = 0;
        reset = 1'b0;

        // Free run: enables on edges 3, 6, 9, 12
        while (cyc < 12) begin
            adv();
            chk_out((cyc % 3) == 0, 1'b0);
        end
        chk("run_count", {24'd0, step_count}, 32'd4);

        // Pause held 10 samples (edges 13..22): press cycle 19, halted from 20
        btn_pause = 1'b1;
        while (cyc < 32) begin
            adv();
            if (cyc == 22) btn_pause = 1'b0;
            chk_out(cyc == 15 || cyc == 18, cyc >= 20);
        end
        chk("halt_count", {24'd0, step_count}, 32'd6);

        // Step held 20 samples, released, pressed again: steps at 40 and 68
        btn_step = 1'b1;
        while (cyc < 80) begin
            adv();
            if (cyc == 52) btn_step = 1'b0;
            if (cyc == 60) btn_step = 1'b1;
            if (cyc == 70) btn_step = 1'b0;
            chk_out(cyc == 40 || cyc == 68, 1'b1);
        end
        chk("step_count", {24'd0, step_count}, 32'd8);

        // Bouncy pause never completes the debounce count
        for (int k = 0; k < 7; k++) begin
            btn_pause = bounce[k];
            adv();
            chk_out(1'b0, 1'b1);
        end
        while (cyc < 92) begin
            adv();
            chk_out(1'b0, 1'b1);
        end
        chk("bounce_count", {24'd0, step_count}, 32'd8);

        // Clean pause press from HALT: RUN at 100, enables at 103 and 106
        btn_pause = 1'b1;
        while (cyc < 107) begin
            adv();
            if (cyc == 100) btn_pause = 1'b0;
            chk_out(cyc == 103 || cyc == 106, cyc < 100);
        end
        chk("resume_count", {24'd0, step_count}, 32'd10);

        // Pause from RUN whose press coincides with the tick due at 115
        btn_pause = 1'b1;
        while (cyc < 126) begin
            adv();
            if (cyc == 117) btn_pause = 1'b0;
            chk_out(cyc == 109 || cyc == 112, cyc >= 115);
        end
        chk("suppress_count", {24'd0, step_count}, 32'd12);

        // Pause and step together from HALT: pause wins, RUN at 134, no STEP
        btn_pause = 1'b1;
        btn_step  = 1'b1;
        while (cyc < 142) begin
            adv();
            if (cyc == 136) begin
                btn_pause = 1'b0;
                btn_step  = 1'b0;
            end
            chk_out(cyc == 137 || cyc == 140, cyc < 134);
        end
        chk("both_count", {24'd0, step_count}, 32'd14);

        // Back to HALT (edge 150), then STEP at 164 with pause debounce in flight
        btn_pause = 1'b1;
        while (cyc < 156) begin
            adv();
            if (cyc == 150) btn_pause = 1'b0;
            chk_out(cyc == 143 || cyc == 146 || cyc == 149, cyc >= 150);
        end
        chk("rehalt_count", {24'd0, step_count}, 32'd17);
        btn_step = 1'b1;
        while (cyc < 164) begin
            adv();
            if (cyc == 159) btn_pause = 1'b1;
            chk_out(cyc == 164, 1'b1);
        end
        chk("instep_count", {24'd0, step_count}, 32'd18);

        // Reset while in STEP: everything clears on the next edge
        reset    = 1'b1;
        btn_step = 1'b0;
        adv();
        chk_out(1'b0, 1'b0);
        chk("mid_rst_count", {24'd0, step_count}, 32'd0);
        reset = 1'b0;

        // Held pause counts as a fresh press: halted from 173, enables 168, 171
        while (cyc < 176) begin
            adv();
            chk_out(cyc == 168 || cyc == 171, cyc >= 173);
        end
        chk("post_rst_count", {24'd0, step_count}, 32'd2);
        btn_pause = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_step_ctrl

// File: doc/step_ctrl.md
Name: step_ctrl

Overview:
- Run/halt/single-step controller that sits directly upstream of the 5-stage pipeline top.
- Debounces the board pause and step push-buttons.
- Generates the single-cycle pipeline advance enable (cpu_en) that gates every PC and pipeline-register update.
- Replaces the free-running divided clock plus toggled pause flag. The whole CPU then runs on one clock, clk, with a clock enable.

Parameters:
- DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required before a button level change is accepted. Minimum 1.
- TICK_DIV, default 50000000: in RUN, one cpu_en pulse every TICK_DIV clk cycles. Minimum 1.
- CNT_W, default 32: width of the issued-enable counter.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- btn_pause  in  1  raw asynchronous pause button, active-high
- btn_step  in  1  raw asynchronous step button, active-high
- cpu_en  out  1  registered; pipeline advances on each clk edge where cpu_en=1
- halted  out  1  registered; 1 in HALT and STEP states
- step_count  out  CNT_W  registered; number of cpu_en pulses issued since reset

Behaviour:
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: counts consecutive cycles where the synced level != stable level. Clears to 0 on any cycle where they are equal.
  - When the count reaches DEBOUNCE_CYCLES, the stable level takes the synced level and the counter clears.
  - Press pulse = 1-cycle pulse on the 0->1 edge of the stable level. Release generates no pulse.
  - Latency: button high, sampled at edge N and held, gives a press pulse high in cycle N+2+DEBOUNCE_CYCLES.
  - A bounce (a low sample) before the count completes restarts the count.
- FSM states: RUN, HALT, STEP.
- RUN:
  - tick counter counts 0..TICK_DIV-1 and wraps.
  - cpu_en=1 for exactly the one cycle after the counter equals TICK_DIV-1, since cpu_en is registered.
  - pause press -> HALT. No further cpu_en is issued; a tick coinciding with the press is suppressed.
  - step press is ignored.
- HALT:
  - cpu_en=0.
  - pause press -> RUN, with the tick counter cleared to 0. The first cpu_en comes TICK_DIV cycles after entry.
  - step press -> STEP.
  - pause and step pressed in the same cycle: pause wins (-> RUN), step discarded.
- STEP:
  - cpu_en=1 for exactly one cycle, then unconditionally -> HALT.
  - Any press while in STEP is discarded. A held step button produces one step per press edge, never auto-repeat.
- halted: 1 in HALT and STEP, 0 in RUN. Registered alongside the state.
- step_count: +1 on every cycle cpu_en=1. Wraps modulo 2^CNT_W without saturation.
- Reset (any cycle, including mid-debounce or in STEP):
  - state=RUN, tick counter=0.
  - Synchronizers, debounce counters and stable levels = 0.
  - cpu_en=0, halted=0, step_count=0.
  - A button held through reset is treated as a new press after the debounce latency.
- TICK_DIV=1: cpu_en is continuously 1 in RUN after the first cycle.

Decomposition:
- Shared package step_ctrl_pkg:
  - state encoding constants ST_RUN=2'd0, ST_HALT=2'd1, ST_STEP=2'd2.
  - default DEBOUNCE_CYCLES and TICK_DIV constants for board builds.
  - sim-scale constants (4, 3).
- Sub-module btn_debounce: synchronizer, debounce counter, stable level, press pulse. Parameter DEBOUNCE_CYCLES; ports clk, reset, btn_raw, press. Instantiated twice.
- Unused encoding 2'd3 recovers to HALT.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=3, CNT_W=8):
- Reset, then free run 12 cycles -> cpu_en high in cycles 3, 6, 9, 12 after reset release; step_count=4; halted=0.
- btn_pause high from edge N, held 10 cycles -> press in cycle N+6; halted=1 from N+7; no cpu_en afterwards; step_count frozen.
- In HALT: btn_step held 20 cycles, then released, then pressed again -> exactly 2 cpu_en pulses, each 1 cycle wide; step_count +2; halted stays 1.
- btn_pause bounce pattern 1,1,0,1,1,1,0 -> no press pulse, state unchanged. Then a clean 1 held for 6+ cycles -> exactly one press.
- In HALT: pause and step rise on the same edge -> state RUN, no STEP pulse; first cpu_en 3 cycles after halted falls.
- Assert reset while in STEP with debounce counting -> next cycle cpu_en=0, halted=0, step_count=0. A held btn_pause yields a press 6 cycles after reset release; the FSM then enters HALT.
